// File: rtl/mm_rd_arbiter_if.sv
// mm_rd_arbiter_if: requester, memory-port and lock-status signals of the motor-memory read arbiter
interface mm_rd_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  localparam int OWN_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        rd_req;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr;
  logic [NUM_REQ-1:0]        rd_lock;
  logic [NUM_REQ-1:0]        rd_gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [DATA_W-1:0]         mem_rd_data;
  logic                      lock_active;
  logic [OWN_W-1:0]          lock_owner;
  logic                      lock_break;
  modport master (
    output rd_req, rd_addr, rd_lock, mem_rd_data,
    input  rd_gnt, rd_valid, rd_data, mem_rd_en, mem_rd_addr, lock_active, lock_owner, lock_break
  );
  modport slave (
    input  rd_req, rd_addr, rd_lock, mem_rd_data,
    output rd_gnt, rd_valid, rd_data, mem_rd_en, mem_rd_addr, lock_active, lock_owner, lock_break
  );
endinterface

// File: rtl/mm_rd_arbiter.sv
// mm_rd_arbiter: round-robin arbiter for the shared motor-memory read port with a bounded bus lock
module mm_rd_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int MAX_LOCK_GNTS = 16
) (
  input logic clock,
  input logic reset,
  mm_rd_arbiter_if.slave bus
);
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK_GNTS + 1);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state;
  logic [OWN_W-1:0] rr_ptr, owner, winner, cand;
  logic [CNT_W-1:0] lock_cnt, cnt_next;
  logic [NUM_REQ-1:0] blocked, eligible, gnt;
  logic [ADDR_W-1:0] addr;
  logic held, found, acquire, brk;
  function automatic int wrap(int s);
    return s >= NUM_REQ ? s - NUM_REQ : s;
  endfunction
  // a lock only restricts arbitration while its owner keeps rd_lock high
  assign held = state == LOCKED && bus.rd_lock[owner];
  always_comb begin
    eligible = held ? bus.rd_req & (NUM_REQ'(1) << owner) : bus.rd_req;
    found = 1'b0;
    winner = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = OWN_W'(wrap(int'(rr_ptr) + k));
      if (eligible[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
    gnt = (found && !reset) ? NUM_REQ'(1) << winner : '0;
    addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      addr = addr | (gnt[i] ? bus.rd_addr[i*ADDR_W +: ADDR_W] : '0);
  end
  assign acquire = |gnt && !held && bus.rd_lock[winner] && !blocked[winner];
  assign cnt_next = acquire ? CNT_W'(1) : lock_cnt + CNT_W'(1);
  assign brk = |gnt && (held || acquire) && cnt_next == CNT_W'(MAX_LOCK_GNTS);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= UNLOCKED;
      rr_ptr <= OWN_W'(NUM_REQ - 1);
      owner <= '0;
      lock_cnt <= '0;
      blocked <= '0;
      bus.rd_valid <= '0;
      bus.lock_break <= 1'b0;
    end else begin
      bus.rd_valid <= gnt;
      bus.lock_break <= brk;
      blocked <= (blocked & bus.rd_lock) | (brk ? gnt : '0);
      if (|gnt) rr_ptr <= winner;
      if (brk || !(held || acquire)) begin
        state <= UNLOCKED;
        owner <= '0;
        lock_cnt <= '0;
      end else if (acquire) begin
        state <= LOCKED;
        owner <= winner;
        lock_cnt <= cnt_next;
      end else if (|gnt) lock_cnt <= cnt_next;
    end
  assign bus.rd_gnt = gnt;
  assign bus.mem_rd_en = |gnt;
  assign bus.mem_rd_addr = addr;
  assign bus.rd_data = bus.mem_rd_data;
  assign bus.lock_active = state == LOCKED;
  assign bus.lock_owner = owner;
endmodule

// File: tb/tb_mm_rd_arbiter.sv
// tb_mm_rd_arbiter: directed stimulus checked every cycle against a behavioural arbiter model
module tb_mm_rd_arbiter;
  localparam int N = 3, AW = 12, DW = 32, MAXL = 16;
  logic clock, reset;
  mm_rd_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  mm_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK_GNTS(MAXL)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int passed = 0, total = 0;
  int glog[$];
  int exp_q[$];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [DW-1:0] memf(logic [AW-1:0] a);
    return {20'hC0DE5, a};
  endfunction
  function automatic int gidx(logic [N-1:0] g);
    if (g == '0) return -1;
    if ($onehot(g)) for (int i = 0; i < N; i++) if (g[i]) return i;
    return 99;
  endfunction
  always @(posedge clock) bus.mem_rd_data <= bus.mem_rd_en ? memf(bus.mem_rd_addr) : 32'hDEADBEEF;
  int m_ptr = N - 1, m_owner = 0, m_cnt = 0;
  bit m_locked = 0, m_brk = 0, pd_ok = 0;
  bit [N-1:0] m_blocked = '0, m_pv = '0;
  logic [DW-1:0] m_pd;
  always @(negedge clock) begin
    int w, i;
    bit held;
    logic [N-1:0] eg;
    logic [AW-1:0] ea;
    if (pd_ok) chk("rd_data", bus.rd_data, m_pd);
    if (reset) begin
      m_ptr = N - 1; m_owner = 0; m_cnt = 0; m_locked = 0; m_brk = 0; m_blocked = '0; m_pv = '0;
      chk("rst_gnt", bus.rd_gnt, 0);
      chk("rst_en", bus.mem_rd_en, 0);
      chk("rst_addr", bus.mem_rd_addr, 0);
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_active", bus.lock_active, 0);
      chk("rst_owner", bus.lock_owner, 0);
      chk("rst_break", bus.lock_break, 0);
      m_pd = 32'hDEADBEEF;
    end else begin
      held = m_locked && bus.rd_lock[m_owner];
      w = -1;
      for (int k = 1; k <= N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && bus.rd_req[i] && (!held || i == m_owner)) w = i;
      end
      eg = w < 0 ? '0 : N'(1) << w;
      ea = w < 0 ? '0 : bus.rd_addr[w*AW +: AW];
      chk("gnt", bus.rd_gnt, eg);
      chk("mem_rd_en", bus.mem_rd_en, w >= 0);
      chk("mem_rd_addr", bus.mem_rd_addr, ea);
      chk("rd_valid", bus.rd_valid, m_pv);
      chk("lock_break", bus.lock_break, m_brk);
      chk("lock_active", bus.lock_active, m_locked);
      chk("lock_owner", bus.lock_owner, m_owner);
      glog.push_back(gidx(bus.rd_gnt));
      m_pv = eg;
      m_brk = 0;
      if (!held) begin m_locked = 0; m_owner = 0; m_cnt = 0; end
      if (w >= 0) begin
        m_ptr = w;
        if (held) m_cnt++;
        else if (bus.rd_lock[w] && !m_blocked[w]) begin m_locked = 1; m_owner = w; m_cnt = 1; end
      end
      for (int j = 0; j < N; j++) if (!bus.rd_lock[j]) m_blocked[j] = 0;
      if (m_locked && m_cnt >= MAXL) begin
        m_brk = 1; m_blocked[m_owner] = 1; m_locked = 0; m_owner = 0; m_cnt = 0;
      end
      m_pd = w < 0 ? 32'hDEADBEEF : memf(ea);
    end
    pd_ok = 1;
  end
  task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lk,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.rd_req = rq;
    bus.rd_lock = lk;
    bus.rd_addr = {a2, a1, a0};
    @(posedge clock);
    #1;
  endtask
  task automatic pins(string nm, int s);
    foreach (exp_q[k]) chk(nm, glog[s+k], exp_q[k]);
    exp_q.delete();
  endtask
  initial begin
    int s;
    reset = 1'b0;
    bus.rd_req = '0;
    bus.rd_lock = '0;
    bus.rd_addr = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    s = glog.size();
    repeat (6) cyc(3'b111, 3'b000, 12'h100, 12'h200, 12'h300);
    exp_q = '{0, 1, 2, 0, 1, 2};
    pins("rr_seq", s);
    cyc(3'b001, 3'b000, 12'h0A0, 12'h0B0, 12'h0C0);
    s = glog.size();
    for (int k = 0; k < 9; k++) begin
      cyc(3'b111, 3'b010, 12'h0A0, 12'h010 + 12'(k), 12'h0C0);
      if (k == 4) begin
        chk("lit_lock_active", bus.lock_active, 1);
        chk("lit_lock_owner", bus.lock_owner, 1);
      end
    end
    cyc(3'b111, 3'b000, 12'h0A0, 12'h019, 12'h0C0);
    chk("lit_release", bus.lock_active, 0);
    cyc(3'b111, 3'b000, 12'h0A0, 12'h019, 12'h0C0);
    repeat (9) exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(0);
    pins("lock1_seq", s);
    cyc(3'b100, 3'b000, 12'h300, 12'h0B0, 12'h3C0);
    s = glog.size();
    for (int k = 0; k < 20; k++) begin
      cyc(3'b101, 3'b001, 12'h300 + 12'(k), 12'h0B0, 12'h3C0);
      if (k == 15) begin
        chk("lit_break_pulse", bus.lock_break, 1);
        chk("lit_break_unlock", bus.lock_active, 0);
      end
      if (k == 16) chk("lit_break_once", bus.lock_break, 0);
      if (k == 17) chk("lit_no_relock", bus.lock_active, 0);
    end
    cyc(3'b101, 3'b000, 12'h320, 12'h0B0, 12'h3C0);
    cyc(3'b101, 3'b001, 12'h321, 12'h0B0, 12'h3C0);
    chk("lit_relock", bus.lock_active, 1);
    repeat (16) exp_q.push_back(0);
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    exp_q.push_back(2); exp_q.push_back(0);
    pins("break_seq", s);
    cyc(3'b000, 3'b000, 12'h000, 12'h000, 12'h000);
    s = glog.size();
    cyc(3'b100, 3'b100, 12'h400, 12'h410, 12'h420);
    repeat (3) cyc(3'b011, 3'b100, 12'h401, 12'h411, 12'h421);
    cyc(3'b111, 3'b100, 12'h402, 12'h412, 12'h422);
    cyc(3'b011, 3'b000, 12'h403, 12'h413, 12'h423);
    exp_q = '{2, -1, -1, -1, 2, 0};
    pins("idle_lock_seq", s);
    cyc(3'b010, 3'b010, 12'h500, 12'h510, 12'h520);
    reset = 1'b1;
    #1;
    chk("lit_rst_valid", bus.rd_valid, 0);
    chk("lit_rst_lock", bus.lock_active, 0);
    cyc(3'b010, 3'b010, 12'h500, 12'h510, 12'h520);
    reset = 1'b0;
    s = glog.size();
    cyc(3'b111, 3'b000, 12'h600, 12'h610, 12'h620);
    exp_q = '{0};
    pins("post_rst", s);
    repeat (2) cyc(3'b000, 3'b000, 12'h000, 12'h000, 12'h000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mm_rd_arbiter.md
Name: mm_rd_arbiter

Overview:
- Shares the single motor-memory read port between N requesters: the motor FSM bus reader, the host command/readback path and telemetry.
- Grants at most one read per cycle using round-robin arbitration, with an optional bus lock for back-to-back register bursts such as the setup-register sweep.
- Routes the one-cycle-latency read data back to the granted requester with a per-requester valid strobe.
- Sits between the requesters and the register memory read port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 12, read address width.
- DATA_W, 32, read data width.
- MAX_LOCK_GNTS, 16, consecutive locked grants allowed before the lock is forcibly broken (≥1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  NUM_REQ  per-requester read request; held until granted.
- rd_addr  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- rd_lock  in  NUM_REQ  per-requester lock request.
- rd_gnt  out  NUM_REQ  one-hot grant, same cycle as the accepted request.
- rd_valid  out  NUM_REQ  one-hot strobe marking rd_data valid for a requester, one cycle after its grant.
- rd_data  out  DATA_W  read data, broadcast to all requesters.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  memory data, valid the cycle after mem_rd_en.
- lock_active  out  1  a lock is currently held.
- lock_owner  out  $clog2(NUM_REQ)  index of the lock holder; 0 when no lock is held.
- lock_break  out  1  one-cycle pulse when a lock is forcibly broken.

Behaviour:
- Reset (asynchronous):
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - lock_active = 0, lock_owner = 0, lock count = 0, blocked flags = 0.
  - rd_valid = 0, lock_break = 0.
  - Combinational outputs are 0 while reset is high: rd_gnt = 0, mem_rd_en = 0, mem_rd_addr = 0.
  - Reset mid-transaction discards the in-flight read; no rd_valid is produced for it.
- Grant generation is combinational:
  - Eligible set = rd_req, masked to the owner alone when lock_active.
  - Winner = first eligible index searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - rd_gnt = one-hot(winner), or 0 if none eligible.
  - mem_rd_en = |rd_gnt.
  - mem_rd_addr = winner's address; 0 when idle.
- On each grant, rr_ptr <= winner. rr_ptr is unchanged when idle.
- Return path:
  - rd_valid <= rd_gnt, registered with 1-cycle latency.
  - rd_data = mem_rd_data, combinational pass-through.
  - Back-to-back grants produce back-to-back valids, 1 read per cycle sustained.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED: granted requester has rd_lock=1 and its blocked flag is 0. Set lock_owner = winner, count = 1.
  - LOCKED:
    - Other requesters receive no grant even if the owner's rd_req=0; the idle cycle is not given away.
    - Each owner grant increments count.
  - LOCKED -> UNLOCKED (release): owner's rd_lock=0 in any cycle. Arbitration in that same cycle is already unlocked, normal round-robin.
  - LOCKED -> UNLOCKED (forced break): a grant brings count to MAX_LOCK_GNTS.
    - lock_break pulses on the next cycle.
    - blocked[owner] is set.
    - The next cycle arbitrates round-robin, and rr_ptr = owner, so the owner has lowest priority.
  - blocked[i] clears when rd_lock[i]=0 for one cycle. While blocked, requester i is still granted normally but cannot re-lock.
- Simultaneous events:
  - Release and new lock request in the same cycle: a new lock may be acquired by the winner.
  - Break and the owner's rd_lock still high: no re-lock (blocked).
- Requester contract: rd_addr stable while rd_req=1 and not granted; dropping rd_req before grant is legal.

Test Plan:
- Reset, then rd_req=3'b111 for 6 cycles with no locks -> grants 0,1,2,0,1,2; each rd_valid one cycle after its grant; mem_rd_addr tracks the winner; rd_data equals mem_rd_data.
- Requester 1 requests with rd_lock=1, addr 0x010..0x018, for 9 cycles while requesters 0 and 2 request continuously -> 9 consecutive grants to 1; lock_owner=1; lock_active=1; after rd_lock drops, next grants 2, 0.
- Requester 0 holds rd_lock and rd_req for 20 cycles with requester 2 requesting, MAX_LOCK_GNTS=16 -> 16 grants to 0, lock_break pulse, then grant 2, then 0 alternating without re-lock until rd_lock[0] goes low for a cycle.
- Lock held by requester 2 with its rd_req low for 3 cycles while 0 and 1 request -> rd_gnt=0 and mem_rd_en=0 for those 3 cycles.
- Assert reset the cycle after a grant to requester 1 -> rd_valid stays 0, lock cleared, first grant after reset goes to 0.
